psum_requantizer: RTL and testbench
===================================

PSUM_REQUANTIZER -- requirements
Module: psum_requantizer

Interface
REQ-001 SHALL have parameter DATA_WIDTH_PSUM, default 32: input partial-sum width, two's complement.
REQ-002 SHALL have parameter FRACTIONAL_BITS_PSUM, default 28: fractional bits of the input partial sum.
REQ-003 SHALL have parameter DATA_WIDTH_OUT, default 16: output width, signed.
REQ-004 SHALL have parameter FRACTIONAL_BITS_OUT, default 13: output fractional bits.
REQ-005 SHALL have parameter FRAME_LENGTH, default 5: expected beats per tlast-delimited frame.
REQ-006 SHALL have port clk, input, 1: sole clock; all logic on its rising edge.
REQ-007 SHALL have port rst, input, 1: reset, synchronous, active-high.
REQ-008 SHALL have port s_axis_psum_tdata, input, DATA_WIDTH_PSUM: partial sum from the bottom processing element of a column.
REQ-009 SHALL have ports s_axis_psum_tvalid (input, 1), s_axis_psum_tready (output, 1) and s_axis_psum_tlast (input, 1): AXI-Stream slave handshake and frame end.
REQ-010 SHALL have port m_axis_res_tdata, output, DATA_WIDTH_OUT: requantized result.
REQ-011 SHALL have ports m_axis_res_tvalid (output, 1), m_axis_res_tready (input, 1) and m_axis_res_tlast (output, 1): AXI-Stream master handshake and frame end.
REQ-012 SHALL have port err_saturation, output, 1: sticky flag, set when any output beat is clipped.
REQ-013 SHALL have port err_frame_length, output, 1: one-cycle pulse on a frame-length violation.

Function
REQ-014 Transfer SHALL occur only on a cycle with tvalid and tready both high.
REQ-015 Datapath SHALL be two register stages: S1 rounds and shifts; S2 saturates and drives m_axis_res_*.
REQ-016 Latency SHALL be 2 cycles from input acceptance to m_axis_res_tvalid when there is no backpressure.
REQ-017 Throughput SHALL be 1 beat/cycle with m_axis_res_tready held high.
REQ-018 S2 SHALL load when it is empty or its output beat is accepted in the same cycle.
REQ-019 S1 SHALL load when it is empty or it passes its beat to S2 in the same cycle.
REQ-020 s_axis_psum_tready SHALL equal (!S1_valid || S1 advancing); a combinational path from m_axis_res_tready is permitted.
REQ-021 With SH = FRACTIONAL_BITS_PSUM - FRACTIONAL_BITS_OUT (15 at defaults), S1 SHALL compute (psum + 2^(SH-1)) >>> SH, arithmetic, in DATA_WIDTH_PSUM+1 bits, with no intermediate overflow (round half up).
REQ-022 S2 SHALL clip to [-2^(DATA_WIDTH_OUT-1), 2^(DATA_WIDTH_OUT-1)-1], i.e. 0x8000..0x7FFF at defaults.
REQ-023 Any clip on a beat loaded into S2 SHALL set err_saturation, which holds until rst.
REQ-024 tlast SHALL travel with its data beat through both stages unchanged.
REQ-025 A beat counter SHALL count accepted input beats within the current frame, range 0..FRAME_LENGTH-1.
REQ-026 Accepted beat with tlast and count != FRAME_LENGTH-1 SHALL pulse err_frame_length for one cycle and clear the counter.
REQ-027 Accepted beat with count == FRAME_LENGTH-1 and no tlast SHALL pulse err_frame_length for one cycle and wrap the counter to 0.
REQ-028 Accepted beat with count == FRAME_LENGTH-1 and tlast SHALL clear the counter with no error.
REQ-029 Data SHALL always be forwarded, including on error beats; the block SHALL never drop or reorder beats.
REQ-030 Output data, valid and last SHALL stay stable while m_axis_res_tvalid is high and m_axis_res_tready is low.

Reset
REQ-031 With rst high at a clock edge, the following SHALL be cleared: S1/S2 valid, m_axis_res_tvalid, m_axis_res_tlast, m_axis_res_tdata, the beat counter, err_saturation and err_frame_length.
REQ-032 s_axis_psum_tready SHALL be 0 while rst is high and 1 on the first cycle after rst deasserts.
REQ-033 Reset mid-frame SHALL discard in-flight beats; the next accepted beat SHALL count as beat 0 of a new frame.

Verification
REQ-034 Input psum 0x10000000 (1.0) -> 0x2000 two cycles later; input 0x00004000 -> 0x0001 (round up); input 0x00003FFF -> 0x0000; input 0xF0000000 (-1.0) -> 0xE000.
REQ-035 Input 0x7FFFFFFF -> 0x7FFF; input 0x80000000 -> 0x8000; err_saturation SHALL be set from the first clip and remain 1 until rst.
REQ-036 Backpressure: stream 6 beats with m_axis_res_tready low for cycles 2-5 -> s_axis_psum_tready low while both stages are full; all 6 outputs arrive in order with no duplicates; tdata stable while stalled.
REQ-037 Frame of 5 beats with tlast on beat 4 -> no error. Then tlast on beat 2 -> one err_frame_length pulse. Then 6 beats with no tlast -> pulse on beat 4; counter restarts.
REQ-038 Assert rst for 1 cycle with S1 and S2 full -> both valids clear next cycle, err flags clear, and a subsequent 5-beat frame with tlast on beat 4 produces no error.

Source files
------------

// File: rtl/psum_requantizer_if.sv
// psum_requantizer_if: AXI-Stream beat bundle (data, valid, ready, last) with master/slave views
interface psum_requantizer_if #(
  parameter int W = 32
);
  logic [W-1:0] tdata;
  logic         tvalid;
  logic         tready;
  logic         tlast;
  modport master(output tdata, tvalid, tlast, input tready);
  modport slave(input tdata, tvalid, tlast, output tready);
endinterface

// File: rtl/psum_requantizer.sv
// psum_requantizer: round/shift a fixed-point partial sum, saturate to the output format, police frame length
module psum_requantizer #(
  parameter int DATA_WIDTH_PSUM      = 32,
  parameter int FRACTIONAL_BITS_PSUM = 28,
  parameter int DATA_WIDTH_OUT       = 16,
  parameter int FRACTIONAL_BITS_OUT  = 13,
  parameter int FRAME_LENGTH         = 5
) (
  input  logic                   clk,
  input  logic                   rst,
  psum_requantizer_if.slave      s_axis_psum,
  psum_requantizer_if.master     m_axis_res,
  output logic                   err_saturation,
  output logic                   err_frame_length
);
  localparam int SH = FRACTIONAL_BITS_PSUM - FRACTIONAL_BITS_OUT;
  localparam int CW = FRAME_LENGTH > 1 ? $clog2(FRAME_LENGTH) : 1;
  localparam logic signed [DATA_WIDTH_PSUM:0] ROUND   = (DATA_WIDTH_PSUM+1)'(2**(SH-1));
  localparam logic signed [DATA_WIDTH_PSUM:0] SAT_MAX = (DATA_WIDTH_PSUM+1)'(2**(DATA_WIDTH_OUT-1)-1);
  localparam logic signed [DATA_WIDTH_PSUM:0] SAT_MIN = ~SAT_MAX;
  logic                              s1_valid;
  logic                              s1_last;
  logic signed [DATA_WIDTH_PSUM:0]   s1_data;
  logic signed [DATA_WIDTH_PSUM:0]   rnd;
  logic [CW-1:0]                     cnt;
  logic                              s_fire;
  logic                              s1_adv;
  logic                              s2_adv;
  logic                              hi;
  logic                              lo;
  logic                              at_end;
  // one extra bit keeps the rounding add from overflowing at the top of the range
  always_comb begin
    s2_adv = !m_axis_res.tvalid || m_axis_res.tready;
    s1_adv = s1_valid && s2_adv;
    s_axis_psum.tready = !rst && (!s1_valid || s1_adv);
    s_fire = s_axis_psum.tvalid && s_axis_psum.tready;
    rnd = ($signed({s_axis_psum.tdata[DATA_WIDTH_PSUM-1], s_axis_psum.tdata}) + ROUND) >>> SH;
    hi = s1_data > SAT_MAX;
    lo = s1_data < SAT_MIN;
    at_end = cnt == CW'(FRAME_LENGTH-1);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_last <= 1'b0;
      s1_data <= '0;
      m_axis_res.tvalid <= 1'b0;
      m_axis_res.tlast <= 1'b0;
      m_axis_res.tdata <= '0;
      cnt <= '0;
      err_saturation <= 1'b0;
      err_frame_length <= 1'b0;
    end else begin
      if (s_axis_psum.tready) s1_valid <= s_axis_psum.tvalid;
      if (s_fire) begin
        s1_data <= rnd;
        s1_last <= s_axis_psum.tlast;
      end
      if (s2_adv) begin
        m_axis_res.tvalid <= s1_valid;
        if (s1_valid) begin
          m_axis_res.tdata <= hi ? SAT_MAX[DATA_WIDTH_OUT-1:0] : lo ? SAT_MIN[DATA_WIDTH_OUT-1:0] : s1_data[DATA_WIDTH_OUT-1:0];
          m_axis_res.tlast <= s1_last;
          err_saturation <= err_saturation | hi | lo;
        end
      end
      // early tlast and missing tlast both flag; the counter restarts either way
      err_frame_length <= s_fire && (s_axis_psum.tlast != at_end);
      if (s_fire) cnt <= (s_axis_psum.tlast || at_end) ? '0 : cnt + CW'(1);
    end
  end
endmodule

// File: tb/tb_psum_requantizer.sv
// tb_psum_requantizer: vector table, directed corner sequences and randomized traffic against a real-arithmetic model
module tb_psum_requantizer;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic err_saturation, err_frame_length;
  always #5 clk = ~clk;
  psum_requantizer_if #(.W(32)) s_if();
  psum_requantizer_if #(.W(16)) m_if();
  psum_requantizer dut (
    .clk(clk),
    .rst(rst),
    .s_axis_psum(s_if),
    .m_axis_res(m_if),
    .err_saturation(err_saturation),
    .err_frame_length(err_frame_length)
  );
  typedef struct {logic [15:0] d; logic l; logic c;} beat_t;
  typedef struct {logic [31:0] p; logic [15:0] d; logic s;} vec_t;
  beat_t sbq[$];
  vec_t tbl[12];
  int checks = 0, failures = 0;
  int cnt_m = 0, fl_pulses = 0, outs = 0;
  logic exp_fl = 0, exp_fl_n, sat_in = 0, sat_m = 0;
  logic prev_stall = 0, prev_l = 0, in_fired = 0, last_s_ready = 0;
  logic [15:0] prev_d = 0;
  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  function automatic beat_t model(logic [31:0] p, logic l);
    real r;
    int v;
    beat_t b;
    r = $floor($itor($signed(p)) / 32768.0 + 0.5);
    v = $rtoi(r);
    b.l = l;
    b.c = (v > 32767) || (v < -32768);
    b.d = v > 32767 ? 16'h7fff : v < -32768 ? 16'h8000 : v[15:0];
    return b;
  endfunction
  task automatic cycle();
    #1;
    chk("err_frame_length", err_frame_length, exp_fl);
    fl_pulses += int'(err_frame_length);
    if (prev_stall) begin
      chk("stall_valid", m_if.tvalid, 1);
      chk("stall_data", m_if.tdata, prev_d);
      chk("stall_last", m_if.tlast, prev_l);
    end
    exp_fl_n = 0;
    last_s_ready = s_if.tready;
    in_fired = s_if.tvalid && s_if.tready;
    if (m_if.tvalid && m_if.tready) begin
      outs++;
      if (sbq.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_output: got %h expected no beat", m_if.tdata);
      end else begin
        beat_t b;
        b = sbq.pop_front();
        chk("out_data", m_if.tdata, b.d);
        chk("out_last", m_if.tlast, b.l);
        sat_m |= b.c;
        if (sat_m) chk("err_sat_set", err_saturation, 1);
        if (!sat_in) chk("err_sat_clear", err_saturation, 0);
      end
    end
    if (in_fired) begin
      beat_t b;
      b = model(s_if.tdata, s_if.tlast);
      sbq.push_back(b);
      sat_in |= b.c;
      exp_fl_n = s_if.tlast != (cnt_m == 4);
      cnt_m = (s_if.tlast || cnt_m == 4) ? 0 : cnt_m + 1;
    end
    prev_stall = m_if.tvalid && !m_if.tready;
    prev_d = m_if.tdata;
    prev_l = m_if.tlast;
    @(posedge clk);
    #1;
    exp_fl = exp_fl_n;
  endtask
  task automatic do_reset(int n);
    rst = 1;
    s_if.tvalid = 0;
    s_if.tlast = 0;
    s_if.tdata = 0;
    m_if.tready = 0;
    repeat (n) begin
      #1;
      chk("tready_in_reset", s_if.tready, 0);
      @(posedge clk);
      #1;
    end
    rst = 0;
    sbq.delete();
    cnt_m = 0;
    exp_fl = 0;
    sat_in = 0;
    sat_m = 0;
    prev_stall = 0;
    #1;
  endtask
  task automatic send(logic [31:0] d, logic l);
    int k;
    k = 0;
    s_if.tdata = d;
    s_if.tlast = l;
    s_if.tvalid = 1;
    do begin
      cycle();
      k++;
    end while (!in_fired && k < 50);
    if (!in_fired) begin
      checks++;
      failures++;
      $display("FAIL send_timeout: got no accept expected accept within 50 cycles");
    end
    s_if.tvalid = 0;
  endtask
  task automatic drain();
    int k;
    k = 0;
    s_if.tvalid = 0;
    m_if.tready = 1;
    while (sbq.size() > 0 && k < 100) begin
      cycle();
      k++;
    end
    cycle();
    cycle();
    chk("drain_empty", sbq.size(), 0);
  endtask
  initial begin
    tbl[0]  = '{32'h10000000, 16'h2000, 1'b0};
    tbl[1]  = '{32'h00004000, 16'h0001, 1'b0};
    tbl[2]  = '{32'h00003FFF, 16'h0000, 1'b0};
    tbl[3]  = '{32'hF0000000, 16'hE000, 1'b0};
    tbl[4]  = '{32'hFFFFC000, 16'h0000, 1'b0};
    tbl[5]  = '{32'hFFFFBFFF, 16'hFFFF, 1'b0};
    tbl[6]  = '{32'h3FFFBFFF, 16'h7FFF, 1'b0};
    tbl[7]  = '{32'hC0000000, 16'h8000, 1'b0};
    tbl[8]  = '{32'h7FFFFFFF, 16'h7FFF, 1'b1};
    tbl[9]  = '{32'h80000000, 16'h8000, 1'b1};
    tbl[10] = '{32'h3FFFC000, 16'h7FFF, 1'b1};
    tbl[11] = '{32'h10000000, 16'h2000, 1'b1};
    do_reset(2);
    chk("rst_in_ready", s_if.tready, 1);
    chk("rst_out_valid", m_if.tvalid, 0);
    chk("rst_out_data", m_if.tdata, 0);
    chk("rst_out_last", m_if.tlast, 0);
    chk("rst_err_sat", err_saturation, 0);
    chk("rst_err_fl", err_frame_length, 0);
    m_if.tready = 1;
    for (int i = 0; i < 12; i++) begin
      send(tbl[i].p, 0);
      chk("latency_s1", m_if.tvalid, 0);
      cycle();
      chk("latency_s2", m_if.tvalid, 1);
      chk("tbl_data", m_if.tdata, tbl[i].d);
      chk("tbl_sat", err_saturation, tbl[i].s);
    end
    drain();
    do_reset(1);
    m_if.tready = 1;
    fl_pulses = 0;
    for (int i = 0; i < 5; i++) send(32'(i) << 15, i == 4);
    drain();
    chk("frame_ok_pulses", fl_pulses, 0);
    fl_pulses = 0;
    for (int i = 0; i < 3; i++) send(32'(i) << 15, i == 2);
    drain();
    chk("frame_short_pulses", fl_pulses, 1);
    fl_pulses = 0;
    for (int i = 0; i < 6; i++) send(32'(i) << 15, 0);
    drain();
    chk("frame_long_pulses", fl_pulses, 1);
    fl_pulses = 0;
    for (int i = 0; i < 4; i++) send(32'(i) << 15, i == 3);
    drain();
    chk("frame_restart_pulses", fl_pulses, 0);
    do_reset(1);
    outs = 0;
    begin
      int sent;
      sent = 0;
      for (int c = 0; c < 40 && outs < 6; c++) begin
        m_if.tready = !(c >= 2 && c <= 5);
        s_if.tvalid = sent < 6;
        s_if.tdata = 32'(sent + 1) << 15;
        s_if.tlast = sent == 4;
        cycle();
        if (in_fired) sent++;
        if (c == 3) chk("bp_in_ready", last_s_ready, 0);
      end
    end
    s_if.tvalid = 0;
    chk("bp_outputs", outs, 6);
    chk("bp_queue_empty", sbq.size(), 0);
    do_reset(1);
    send(32'h7FFFFFFF, 0);
    send(32'h80000000, 0);
    chk("full_out_valid", m_if.tvalid, 1);
    chk("full_err_sat", err_saturation, 1);
    chk("full_in_ready", s_if.tready, 0);
    do_reset(1);
    chk("midrst_out_valid", m_if.tvalid, 0);
    chk("midrst_err_sat", err_saturation, 0);
    chk("midrst_err_fl", err_frame_length, 0);
    chk("midrst_in_ready", s_if.tready, 1);
    m_if.tready = 1;
    fl_pulses = 0;
    for (int i = 0; i < 5; i++) send(32'h00008000 * 32'(i), i == 4);
    drain();
    chk("midrst_frame_pulses", fl_pulses, 0);
    do_reset(1);
    for (int c = 0; c < 600; c++) begin
      logic [31:0] d;
      d = $urandom_range(0, 2) == 0 ? $urandom : ($urandom_range(0, 32'h7fffffff) >> 2);
      if ($urandom_range(0, 1) == 1) d = -d;
      s_if.tvalid = $urandom_range(0, 3) != 0;
      s_if.tdata = d;
      s_if.tlast = $urandom_range(0, 5) == 0;
      m_if.tready = $urandom_range(0, 3) != 0;
      cycle();
    end
    drain();
    chk("rand_err_sat_final", err_saturation, sat_in);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
